// File: rtl/wb_board_arbiter_if.sv
// wb_board_arbiter_if
//   One wishbone-style board-IO port: a requester drives select, word
//   address, byte lanes, write data and write enable; the responder returns
//   read data, a one-cycle ack and an error flag that qualifies the ack.
// Parameters
//   ADDR_W  word address width (DEV_ADDR_BITS-2)
// Modports
//   master  requester side (CPU data bus, debug/DMA engine)
//   slave   responder side including the error flag (arbiter upstream ports)
//   bridge  requester side without the error flag (arbiter towards a plain
//           board-IO register block, which has no error signalling)
interface wb_board_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [31:0]       wdata;
  logic              we;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;

  modport master (output cs, addr, sel, wdata, we, input rdata, ack, err);
  modport slave  (input cs, addr, sel, wdata, we, output rdata, ack, err);
  modport bridge (output cs, addr, sel, wdata, we, input rdata, ack);
endinterface

// File: rtl/wb_board_arbiter.sv
// wb_board_arbiter
//   Two-master arbiter in front of one board-IO slave (switches, buttons,
//   LEDs, 7-segment registers). One transaction runs at a time, every
//   slave-side signal is registered, and a bus timeout turns a silent slave
//   into an error ack.
// Parameters
//   DEV_ADDR_BITS  I/O space address width; word address is [DEV_ADDR_BITS-1:2]
//   TIMEOUT        BUSY cycles without slave ack before an error ack; 0 = off
//   PRIORITY_M0    0 = round-robin on ties, 1 = m0 always wins ties
// Ports
//   clk        single clock for masters, slave and arbiter
//   rst        synchronous active-high reset
//   m0, m1     upstream master ports (slave modport of wb_board_arbiter_if)
//   s          downstream slave port (bridge modport, registered outputs)
//   timeout_o  one-cycle pulse when a timeout error ack is issued
module wb_board_arbiter #(
  parameter int DEV_ADDR_BITS = 8,
  parameter int TIMEOUT       = 255,
  parameter int PRIORITY_M0   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_board_arbiter_if.slave    m0,
  wb_board_arbiter_if.slave    m1,
  wb_board_arbiter_if.bridge   s,
  output logic                 timeout_o
);

  localparam int AW = DEV_ADDR_BITS - 2;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [15:0]     timer_q, timer_d;
  logic            s_cs_q, s_cs_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [3:0]      s_sel_q, s_sel_d;
  logic [31:0]     s_data_q, s_data_d;
  logic            s_we_q, s_we_d;
  logic [31:0]     m0_data_q, m0_data_d, m1_data_q, m1_data_d;
  logic            m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic            m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic            timeout_q, timeout_d;

  logic            req_any;
  logic            pick_m1;
  logic            timeout_hit;

  // m1 wins when it is the only requester, or on a round-robin tie when m0
  // held the previous grant.
  assign req_any     = m0.cs | m1.cs;
  assign pick_m1     = m1.cs & (~m0.cs | ((PRIORITY_M0 == 0) & ~last_grant_q));
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMEOUT_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a slave ack beats the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = BUSY;
      BUSY:    if (s.ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values. Master-side responses are single-cycle
  // pulses, so they default to zero and are only raised on completion.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    s_cs_d       = s_cs_q;
    s_addr_d     = s_addr_q;
    s_sel_d      = s_sel_q;
    s_data_d     = s_data_q;
    s_we_d       = s_we_q;
    m0_data_d    = '0;
    m0_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_data_d    = '0;
    m1_ack_d     = 1'b0;
    m1_err_d     = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d  = pick_m1;
          s_cs_d   = 1'b1;
          s_addr_d = pick_m1 ? m1.addr  : m0.addr;
          s_sel_d  = pick_m1 ? m1.sel   : m0.sel;
          s_data_d = pick_m1 ? m1.wdata : m0.wdata;
          s_we_d   = pick_m1 ? m1.we    : m0.we;
          timer_d  = '0;
        end
      end
      BUSY: begin
        if (s.ack) begin
          s_cs_d       = 1'b0;
          last_grant_d = grant_q;
          if (grant_q) begin
            m1_ack_d  = 1'b1;
            m1_data_d = s.rdata;
          end else begin
            m0_ack_d  = 1'b1;
            m0_data_d = s.rdata;
          end
        end else if (timeout_hit) begin
          s_cs_d       = 1'b0;
          last_grant_d = grant_q;
          timeout_d    = 1'b1;
          if (grant_q) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any in-flight transaction silently
  // and hands the next tie to m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      s_cs_q       <= 1'b0;
      s_addr_q     <= '0;
      s_sel_q      <= '0;
      s_data_q     <= '0;
      s_we_q       <= 1'b0;
      m0_data_q    <= '0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_data_q    <= '0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      s_cs_q       <= s_cs_d;
      s_addr_q     <= s_addr_d;
      s_sel_q      <= s_sel_d;
      s_data_q     <= s_data_d;
      s_we_q       <= s_we_d;
      m0_data_q    <= m0_data_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m1_data_q    <= m1_data_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign s.cs     = s_cs_q;
  assign s.addr   = s_addr_q;
  assign s.sel    = s_sel_q;
  assign s.wdata  = s_data_q;
  assign s.we     = s_we_q;
  assign m0.rdata = m0_data_q;
  assign m0.ack   = m0_ack_q;
  assign m0.err   = m0_err_q;
  assign m1.rdata = m1_data_q;
  assign m1.ack   = m1_ack_q;
  assign m1.err   = m1_err_q;
  assign timeout_o = timeout_q;

endmodule
